// File: rtl/pc_ir_unit.sv
// PC / IR / ALUOut holding stage of the multi-cycle CPU, with a sticky
// misaligned-target fault trap and a wrapping instruction-fetch counter.
module pc_ir_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCWrite,
  input  logic             PCWriteCond,
  input  logic [1:0]       PCSource,
  input  logic             IRWrite,
  input  logic             Zero,
  input  logic [31:0]      ALUResult,
  input  logic [31:0]      RegRs,
  input  logic [31:0]      MemData,
  output logic [31:0]      PC,
  output logic [31:0]      Instruction,
  output logic [5:0]       OpCode,
  output logic [5:0]       Funct,
  output logic [31:0]      ALUOut,
  output logic             fault,
  output logic [31:0]      fault_pc,
  output logic [CNT_W-1:0] fetch_count
);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [31:0]      aluout_q;
  logic             fault_q, fault_d;
  logic [31:0]      fault_pc_q, fault_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pc_en;
  logic [31:0]      next_pc;

  assign pc_en = PCWrite | (PCWriteCond & Zero);

  always_comb begin
    next_pc = ALUResult;
    case (PCSource)
      2'b00: next_pc = ALUResult;
      2'b01: next_pc = aluout_q;
      2'b10: next_pc = {pc_q[31:28], ir_q[25:0], 2'b00};
      2'b11: next_pc = RegRs;
      default: next_pc = ALUResult;
    endcase
  end

  // Everything except ALUOut freezes once faulted; a misaligned target never reaches PC.
  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    cnt_d      = cnt_q;
    if (!fault_q) begin
      if (pc_en) begin
        if (next_pc[1:0] == 2'b00) begin
          pc_d = next_pc;
        end else begin
          fault_d    = 1'b1;
          fault_pc_d = next_pc;
        end
      end
      if (IRWrite) begin
        ir_d  = MemData;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      aluout_q   <= '0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      aluout_q   <= ALUResult;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign PC          = pc_q;
  assign Instruction = ir_q;
  assign OpCode      = ir_q[31:26];
  assign Funct       = ir_q[5:0];
  assign ALUOut      = aluout_q;
  assign fault       = fault_q;
  assign fault_pc    = fault_pc_q;
  assign fetch_count = cnt_q;

endmodule
